rot_scan_ctrl: RTL
==================

Name: rot_scan_ctrl

Overview:
- Sequencer that sits directly upstream of the 16-bit case-based rotators (left and right variants).
- Holds a 16-bit pattern and drives the rotators' data and amount inputs. Steps the rotate amount at a programmable tick rate, so the rotator output scrolls (LED banner / 7-seg marquee).
- Supports start, pause, stop and single-step, plus a direction select that tells downstream which rotator output to use.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per automatic step in RUN; legal range 1..2^32-1; TICK_DIV=1 steps every cycle.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- load  input  1  one-cycle pulse: capture din, clear amt and tick counter
- din  input  16  pattern to be rotated
- start  input  1  pulse: IDLE->RUN or PAUSE->RUN; latches dir
- stop  input  1  pulse: RUN->PAUSE, PAUSE->IDLE
- step  input  1  pulse: advance amt by one, honoured only in IDLE or PAUSE
- dir  input  1  1 = left rotate, 0 = right rotate
- a  output  16  registered pattern to the rotator data input
- amt  output  4  registered rotate amount to the rotator amount input
- left  output  1  latched direction; downstream selects the left or right rotator output
- running  output  1  high while in RUN
- wrap  output  1  one-cycle pulse when amt advances from 15 to 0

Behaviour:
- Single clock domain, synchronous active-high reset. Reset values: a=0, amt=0, left=0, running=0, wrap=0, state=IDLE, tick counter=0.
- Reset mid-operation overrides every input in the same cycle.
- States:
  - IDLE: start -> RUN. step -> amt+1, state stays IDLE.
  - RUN: tick counter increments each cycle. When the counter reaches TICK_DIV-1 it clears to 0 and amt advances by 1. stop -> PAUSE. step is ignored.
  - PAUSE: counter holds its value. start -> RUN and counting resumes from the held value. step -> amt+1. stop -> IDLE with amt=0 and counter=0.
- Simultaneous start and stop: stop wins.
- load has top priority over start, stop and step, in any state:
  - a=din, amt=0, counter=0 on the next edge.
  - State is unchanged. A start/stop in the same cycle is still applied to the state; a step in the same cycle is ignored.
- dir is sampled into left only on an accepted start (IDLE->RUN or PAUSE->RUN) and on load. At all other times left holds its value.
- Advance arithmetic: 4-bit modulo-16. amt=15 advancing gives amt=0 with wrap=1 for exactly that one cycle; otherwise wrap=0. Step-driven advances pulse wrap the same way.
- Latency: every output is registered. An automatic advance appears on amt in the cycle after the counter reaches TICK_DIV-1. A step or load takes effect on the next edge.
- running = (state==RUN); it is registered alongside the state.
- Tick counter is 32 bits. With TICK_DIV=1 the counter stays at 0 and amt advances every RUN cycle.
- a changes only on load; the rotation itself is done downstream.

Test Plan:
- Reset, then idle 10 cycles -> a=0x0000, amt=0, left=0, running=0, wrap=0 throughout.
- TICK_DIV=4, load din=0x8001 with dir=1, start -> running=1 the next cycle. amt goes 1,2,3 at 4-cycle intervals. left=1, a=0x8001.
- TICK_DIV=1, load 0x00FF, start, run 16 cycles -> amt steps 0..15 then 0; wrap is high exactly one cycle, at the 15->0 transition.
- TICK_DIV=4, RUN for 2 cycles, stop -> PAUSE with amt held. Two step pulses -> amt+2. start -> the next advance comes 2 cycles later (held counter). stop, stop -> IDLE with amt=0.
- In RUN: start and stop in the same cycle -> PAUSE. load din=0x1234 together with step -> a=0x1234, amt=0, the step is ignored and the state is unchanged.
- While amt=7 in RUN, assert reset for 1 cycle -> all outputs return to reset values on the next edge. Change dir with no start/load -> left unchanged.

Source files
------------

// File: rtl/rot_scan_ctrl.sv
// -----------------------------------------------------------------------------
// rot_scan_ctrl
//   Sequencer for the 16-bit case-based rotators. It holds a pattern and
//   steps the rotate amount at a programmable tick rate, so the rotator
//   output scrolls across a display (LED banner, 7-segment marquee).
//   It supports start, pause, stop and single-step control. It also latches
//   a direction bit, which tells downstream whether to use the left or the
//   right rotator output.
//
// Parameters
//   TICK_DIV  clk cycles per automatic step while running (1 .. 2^32-1)
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   load     in   pulse: capture din, clear amt and tick counter, latch dir
//   din      in   [15:0] pattern to rotate
//   start    in   pulse: IDLE->RUN or PAUSE->RUN, latches dir
//   stop     in   pulse: RUN->PAUSE, PAUSE->IDLE (clears amt and counter)
//   step     in   pulse: amt+1, only in IDLE or PAUSE
//   dir      in   1 = left rotate, 0 = right rotate
//   a        out  [15:0] registered pattern to the rotator data input
//   amt      out  [3:0]  registered rotate amount
//   left     out  latched direction
//   running  out  high while in RUN
//   wrap     out  one-cycle pulse when amt advances from 15 to 0
// -----------------------------------------------------------------------------
module rot_scan_ctrl #(
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] din,
   input  logic        start,
   input  logic        stop,
   input  logic        step,
   input  logic        dir,
   output logic [15:0] a,
   output logic [3:0]  amt,
   output logic        left,
   output logic        running,
   output logic        wrap
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2
   } state_t;

   localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

   state_t      state_q, state_d;
   logic [15:0] a_q, a_d;
   logic [3:0]  amt_q, amt_d;
   logic [31:0] cnt_q, cnt_d;
   logic        left_q, left_d;
   logic        running_q, running_d;
   logic        wrap_q, wrap_d;
   logic        adv;
   logic        clr;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      amt_d   = amt_q;
      cnt_d   = cnt_q;
      left_d  = left_q;
      wrap_d  = 1'b0;
      adv     = 1'b0;
      clr     = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Stop wins over start, so a simultaneous pair leaves us idle.
            if (start && !stop) begin
               state_d = S_RUN;
               left_d  = dir;
            end
            if (step) adv = 1'b1;
         end
         S_RUN: begin
            // The counter runs in every RUN cycle, including the one in
            // which stop is sampled. start and step are ignored here.
            if (cnt_q == TICK_LAST) begin
               cnt_d = '0;
               adv   = 1'b1;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
            if (stop) state_d = S_PAUSE;
         end
         S_PAUSE: begin
            // The counter holds, so a resumed RUN finishes the current tick.
            if (stop) begin
               state_d = S_IDLE;
               clr     = 1'b1;
            end else begin
               if (start) begin
                  state_d = S_RUN;
                  left_d  = dir;
               end
               if (step) adv = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (adv) begin
         amt_d  = amt_q + 4'd1;
         wrap_d = (amt_q == 4'd15);
      end

      if (clr) begin
         amt_d  = '0;
         cnt_d  = '0;
         wrap_d = 1'b0;
      end

      // load overrides any advance, including a same-cycle step. The state
      // transition chosen above still applies.
      if (load) begin
         a_d    = din;
         amt_d  = '0;
         cnt_d  = '0;
         wrap_d = 1'b0;
         left_d = dir;
      end

      running_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         amt_q     <= '0;
         cnt_q     <= '0;
         left_q    <= 1'b0;
         running_q <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         amt_q     <= amt_d;
         cnt_q     <= cnt_d;
         left_q    <= left_d;
         running_q <= running_d;
         wrap_q    <= wrap_d;
      end
   end

   assign a       = a_q;
   assign amt     = amt_q;
   assign left    = left_q;
   assign running = running_q;
   assign wrap    = wrap_q;

endmodule
